// File: rtl/mem_stage_sized_if.sv
// EX/MEM -> MEM -> MEM/WB bundle for mem_stage_sized.
// The upstream pipeline drives xm_*/alu_out; the MEM stage drives stall_o, mw_* and the error pulses.
interface mem_stage_sized_if #(
    parameter int RD_W = 5
);
    logic            xm_valid;
    logic            xm_memtoreg;
    logic            xm_regwrite;
    logic            xm_memread;
    logic            xm_memwrite;
    logic [1:0]      xm_size;
    logic            xm_unsigned;
    logic [31:0]     alu_out;
    logic [RD_W-1:0] xm_rd;
    logic [31:0]     xm_md;

    logic            stall_o;
    logic            mw_valid;
    logic            mw_memtoreg;
    logic            mw_regwrite;
    logic [31:0]     mw_aluout;
    logic [31:0]     mw_mdr;
    logic [RD_W-1:0] mw_rd;
    logic            misalign_o;
    logic            parity_err_o;

    modport master (
        output xm_valid, xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite,
        output xm_size, xm_unsigned, alu_out, xm_rd, xm_md,
        input  stall_o, mw_valid, mw_memtoreg, mw_regwrite, mw_aluout,
        input  mw_mdr, mw_rd, misalign_o, parity_err_o
    );

    modport slave (
        input  xm_valid, xm_memtoreg, xm_regwrite, xm_memread, xm_memwrite,
        input  xm_size, xm_unsigned, alu_out, xm_rd, xm_md,
        output stall_o, mw_valid, mw_memtoreg, mw_regwrite, mw_aluout,
        output mw_mdr, mw_rd, misalign_o, parity_err_o
    );
endinterface

// File: rtl/mem_stage_sized.sv
// Pipeline MEM stage: sized data memory, LAT-cycle accesses, byte/half/word with extension.
// Define MEM_PARITY_EN to store one even-parity bit per byte lane and flag load mismatches.
module mem_stage_sized #(
    parameter int DEPTH_LOG2 = 7,
    parameter int LAT        = 2,
    parameter int RD_W       = 5
) (
    input  logic               clk,
    input  logic               rst,
    mem_stage_sized_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

    logic [31:0] mem_q [DEPTH];

    logic [CW-1:0]         cnt_q,         cnt_d;
    logic                  mw_valid_q,    mw_valid_d;
    logic                  mw_memtoreg_q, mw_memtoreg_d;
    logic                  mw_regwrite_q, mw_regwrite_d;
    logic [31:0]           mw_aluout_q,   mw_aluout_d;
    logic [31:0]           mw_mdr_q,      mw_mdr_d;
    logic [RD_W-1:0]       mw_rd_q,       mw_rd_d;
    logic                  misalign_q,    misalign_d;
    logic                  parity_err_q,  parity_err_d;

    logic [DEPTH_LOG2-1:0] idx_s;
    logic [1:0]            lane_s;
    logic                  is_mem_s;
    logic                  aligned_s;
    logic                  mem_op_s;
    logic                  misalign_s;
    logic                  stall_s;
    logic                  do_store_s;
    logic                  do_load_s;
    logic [3:0]            be_s;
    logic [31:0]           wdata_s;
    logic [31:0]           rword_s;
    logic [7:0]            byte_s;
    logic [15:0]           half_s;
    logic [31:0]           ldata_s;
    logic                  par_bad_s;

    assign idx_s    = bus.alu_out[DEPTH_LOG2+1:2];
    assign lane_s   = bus.alu_out[1:0];
    assign is_mem_s = bus.xm_memread | bus.xm_memwrite;
    assign rword_s  = mem_q[idx_s];

    // Alignment rule, byte-lane enables and replicated store data by access size.
    always_comb begin
        aligned_s = 1'b1;
        be_s      = 4'b1111;
        wdata_s   = bus.xm_md;
        case (bus.xm_size)
            2'b00: begin
                aligned_s = 1'b1;
                be_s      = 4'b0001 << lane_s;
                wdata_s   = {4{bus.xm_md[7:0]}};
            end
            2'b01: begin
                aligned_s = ~bus.alu_out[0];
                be_s      = lane_s[1] ? 4'b1100 : 4'b0011;
                wdata_s   = {2{bus.xm_md[15:0]}};
            end
            default: begin
                aligned_s = (lane_s == 2'b00);
                be_s      = 4'b1111;
                wdata_s   = bus.xm_md;
            end
        endcase
    end

    assign mem_op_s   = bus.xm_valid & is_mem_s & aligned_s;
    assign misalign_s = bus.xm_valid & is_mem_s & ~aligned_s;
    // Reset must drop the stall immediately even though the access is still presented upstream.
    assign stall_s    = mem_op_s & (cnt_q != CNT_LAST) & ~rst;
    assign do_store_s = mem_op_s & ~stall_s & bus.xm_memwrite & ~rst;
    assign do_load_s  = mem_op_s & ~stall_s & bus.xm_memread & ~bus.xm_memwrite;

    // Lane selection and sign/zero extension of load data.
    always_comb begin
        byte_s = rword_s[{lane_s, 3'b000} +: 8];
        half_s = rword_s[{lane_s[1], 4'b0000} +: 16];
        case (bus.xm_size)
            2'b00:   ldata_s = bus.xm_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
            2'b01:   ldata_s = bus.xm_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            default: ldata_s = rword_s;
        endcase
    end

    // Data memory byte-lane write; contents survive reset.
    always_ff @(posedge clk) begin
        if (do_store_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
                end
            end
        end
    end

`ifdef MEM_PARITY_EN
    logic [3:0] par_q [DEPTH];

    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

    // Parity bits follow their data lane on every store.
    always_ff @(posedge clk) begin
        if (do_store_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    par_q[idx_s][i] <= even_par(wdata_s[8*i +: 8]);
                end
            end
        end
    end

    // Any selected lane whose stored parity disagrees with its data is a mismatch.
    always_comb begin
        par_bad_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (be_s[i] && (par_q[idx_s][i] != even_par(rword_s[8*i +: 8]))) begin
                par_bad_s = 1'b1;
            end else begin
                par_bad_s = par_bad_s;
            end
        end
    end
`else
    assign par_bad_s = 1'b0;
`endif

    // Next state: a stalled cycle counts and injects a bubble, otherwise the slot advances.
    always_comb begin
        cnt_d         = cnt_q;
        mw_valid_d    = mw_valid_q;
        mw_memtoreg_d = mw_memtoreg_q;
        mw_regwrite_d = mw_regwrite_q;
        mw_aluout_d   = mw_aluout_q;
        mw_mdr_d      = mw_mdr_q;
        mw_rd_d       = mw_rd_q;
        misalign_d    = 1'b0;
        parity_err_d  = 1'b0;
        if (stall_s) begin
            cnt_d         = cnt_q + CW'(1);
            mw_valid_d    = 1'b0;
            mw_regwrite_d = 1'b0;
        end else begin
            cnt_d         = '0;
            mw_valid_d    = bus.xm_valid;
            mw_memtoreg_d = bus.xm_memtoreg;
            mw_regwrite_d = bus.xm_valid & bus.xm_regwrite & ~misalign_s;
            mw_aluout_d   = bus.alu_out;
            mw_rd_d       = bus.xm_rd;
            misalign_d    = misalign_s;
            parity_err_d  = do_load_s & par_bad_s;
            if (do_load_s) begin
                mw_mdr_d = ldata_s;
            end else begin
                mw_mdr_d = mw_mdr_q;
            end
        end
    end

    // Latency counter and MEM/WB latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            mw_valid_q    <= 1'b0;
            mw_memtoreg_q <= 1'b0;
            mw_regwrite_q <= 1'b0;
            mw_aluout_q   <= 32'h0000_0000;
            mw_mdr_q      <= 32'h0000_0000;
            mw_rd_q       <= '0;
            misalign_q    <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            mw_valid_q    <= mw_valid_d;
            mw_memtoreg_q <= mw_memtoreg_d;
            mw_regwrite_q <= mw_regwrite_d;
            mw_aluout_q   <= mw_aluout_d;
            mw_mdr_q      <= mw_mdr_d;
            mw_rd_q       <= mw_rd_d;
            misalign_q    <= misalign_d;
            parity_err_q  <= parity_err_d;
        end
    end

    assign bus.stall_o      = stall_s;
    assign bus.mw_valid     = mw_valid_q;
    assign bus.mw_memtoreg  = mw_memtoreg_q;
    assign bus.mw_regwrite  = mw_regwrite_q;
    assign bus.mw_aluout    = mw_aluout_q;
    assign bus.mw_mdr       = mw_mdr_q;
    assign bus.mw_rd        = mw_rd_q;
    assign bus.misalign_o   = misalign_q;
    assign bus.parity_err_o = parity_err_q;
endmodule

// File: tb/tb_mem_stage_sized.sv
// Self-checking bench for mem_stage_sized (LAT=3): directed scenarios plus a randomized run
// against a byte-addressed reference memory model. MEM_PARITY_EN enables the parity scenario.
module tb_mem_stage_sized;
    localparam int DL   = 7;
    localparam int LAT  = 3;
    localparam int RD_W = 5;
    localparam int NW   = 1 << DL;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_stage_sized_if #(.RD_W(RD_W)) bus ();
    mem_stage_sized #(.DEPTH_LOG2(DL), .LAT(LAT), .RD_W(RD_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] ref_mem [NW];
    logic [31:0] ref_mdr;

    typedef struct {
        logic valid; logic memtoreg; logic regwrite; logic ld; logic st;
        logic [1:0] size; logic uns; logic [31:0] addr; logic [RD_W-1:0] rdst; logic [31:0] md;
    } op_t;

    typedef struct {
        int stalls; logic valid; logic memtoreg; logic regwrite; logic [31:0] aluout;
        logic [31:0] mdr; logic [RD_W-1:0] rd; logic misalign; logic perr;
    } exp_t;

    function automatic op_t mk(input logic v, input logic m2r, input logic rw, input logic ld,
                               input logic st, input logic [1:0] sz, input logic uns,
                               input logic [31:0] a, input logic [RD_W-1:0] r, input logic [31:0] md);
        op_t o;
        o.valid = v; o.memtoreg = m2r; o.regwrite = rw; o.ld = ld; o.st = st;
        o.size = sz; o.uns = uns; o.addr = a; o.rdst = r; o.md = md;
        return o;
    endfunction

    // Reference: byte-addressed memory arithmetic on whole words, independent of lane enables.
    function automatic exp_t model(input op_t o);
        exp_t e;
        int nbytes; int w; int sh;
        logic [31:0] mask; logic [31:0] word;
        nbytes = (o.size == 2'b00) ? 1 : (o.size == 2'b01) ? 2 : 4;
        w  = int'((o.addr / 32'd4) % NW);
        sh = 8 * int'(o.addr % 32'd4);
        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        e.stalls = 0; e.valid = o.valid; e.memtoreg = o.memtoreg;
        e.regwrite = o.valid & o.regwrite; e.aluout = o.addr; e.rd = o.rdst;
        e.misalign = 1'b0; e.perr = 1'b0;
        if (o.valid && (o.ld || o.st) && (o.addr % nbytes) != 0) begin
            e.misalign = 1'b1;
            e.regwrite = 1'b0;
        end else if (o.valid && (o.ld || o.st)) begin
            e.stalls = LAT - 1;
            if (o.st) begin
                ref_mem[w] = (ref_mem[w] & ~(mask << sh)) | ((o.md & mask) << sh);
            end else begin
                word = (ref_mem[w] >> sh) & mask;
                if (!o.uns && word[8*nbytes-1]) word = word | ~mask;
                ref_mdr = word;
            end
        end
        e.mdr = ref_mdr;
        return e;
    endfunction

    task automatic drive(input op_t o);
        bus.xm_valid = o.valid; bus.xm_memtoreg = o.memtoreg; bus.xm_regwrite = o.regwrite;
        bus.xm_memread = o.ld; bus.xm_memwrite = o.st; bus.xm_size = o.size;
        bus.xm_unsigned = o.uns; bus.alu_out = o.addr; bus.xm_rd = o.rdst; bus.xm_md = o.md;
    endtask

    task automatic idle();
        drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, '0, 32'h0));
    endtask

    // Present an op mid-cycle, ride out the stall (bounded), return just after the completing edge.
    task automatic apply(input op_t o, output int stalls, output bit bub_bad);
        drive(o);
        #1;
        stalls = 0;
        bub_bad = 1'b0;
        while (bus.stall_o === 1'b1 && stalls < LAT + 4) begin
            @(posedge clk); #1;
            if (bus.mw_valid !== 1'b0 || bus.mw_regwrite !== 1'b0) bub_bad = 1'b1;
            stalls++;
        end
        @(posedge clk); #1;
        idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.stall_o); end
        n_vec++; if ({bus.mw_valid, bus.mw_memtoreg, bus.mw_regwrite, bus.mw_rd, bus.misalign_o, bus.parity_err_o} !== '0) begin
            n_err++; $display("FAIL reset_ctl: got v%b m%b w%b rd%0d mis%b par%b want all 0", bus.mw_valid, bus.mw_memtoreg,
                              bus.mw_regwrite, bus.mw_rd, bus.misalign_o, bus.parity_err_o); end
        n_vec++; if ({bus.mw_aluout, bus.mw_mdr} !== 64'h0) begin n_err++; $display("FAIL reset_data: got alu %h mdr %h want 0", bus.mw_aluout, bus.mw_mdr); end
        @(negedge clk);
        rst = 1'b0;
        ref_mdr = 32'h0;
    endtask

    task automatic test_word();
        exp_t e; int st; bit bb;
        e = model(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 5'd0, 32'hDEADBEEF));
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 5'd0, 32'hDEADBEEF), st, bb);
        n_vec++; if (st != 2) begin n_err++; $display("FAIL sw_stalls: got %0d want 2", st); end
        n_vec++; if (bb) begin n_err++; $display("FAIL sw_bubble: got non-bubble want mw_valid=0"); end
        n_vec++; if (bus.mw_valid !== 1'b1 || bus.mw_regwrite !== 1'b0) begin n_err++; $display("FAIL sw_done: got v%b w%b want v1 w0", bus.mw_valid, bus.mw_regwrite); end
        e = model(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 5'd7, 32'h0));
        apply(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 5'd7, 32'h0), st, bb);
        n_vec++; if (st != 2 || bb) begin n_err++; $display("FAIL lw_stalls: got %0d bubble_bad %b want 2 0", st, bb); end
        n_vec++; if (bus.mw_mdr !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_mdr: got %h want deadbeef", bus.mw_mdr); end
        n_vec++; if (bus.mw_regwrite !== 1'b1 || bus.mw_rd !== 5'd7 || bus.mw_memtoreg !== 1'b1) begin
            n_err++; $display("FAIL lw_ctl: got w%b rd%0d m%b want w1 rd7 m1", bus.mw_regwrite, bus.mw_rd, bus.mw_memtoreg); end
    endtask

    task automatic test_byte_half();
        exp_t e; int st; bit bb;
        logic [31:0] want [5];
        op_t ops [5];
        e = model(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 5'd0, 32'h00000080));
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 5'd0, 32'h00000080), st, bb);
        ops[0] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 5'd1, 32'h0); want[0] = 32'hFFFFFF80;
        ops[1] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 5'd2, 32'h0); want[1] = 32'h00000080;
        ops[2] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 5'd3, 32'h0); want[2] = 32'hDEAD80EF;
        ops[3] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 5'd4, 32'h0); want[3] = 32'hFFFFDEAD;
        ops[4] = mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 5'd5, 32'h0); want[4] = 32'h0000DEAD;
        for (int i = 0; i < 5; i++) begin
            e = model(ops[i]);
            apply(ops[i], st, bb);
            n_vec++; if (bus.mw_mdr !== want[i]) begin n_err++; $display("FAIL subword_ld%0d: got %h want %h", i, bus.mw_mdr, want[i]); end
        end
    endtask

    task automatic test_misalign();
        exp_t e; int st; bit bb;
        e = model(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h13, 5'd6, 32'h0));
        apply(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h13, 5'd6, 32'h0), st, bb);
        n_vec++; if (st != 0) begin n_err++; $display("FAIL lh_mis_stall: got %0d want 0", st); end
        n_vec++; if (bus.misalign_o !== 1'b1 || bus.mw_regwrite !== 1'b0) begin n_err++; $display("FAIL lh_mis: got mis%b w%b want mis1 w0", bus.misalign_o, bus.mw_regwrite); end
        n_vec++; if (bus.mw_mdr !== e.mdr) begin n_err++; $display("FAIL lh_mis_mdr_hold: got %h want %h", bus.mw_mdr, e.mdr); end
        @(posedge clk); #1;
        n_vec++; if (bus.misalign_o !== 1'b0) begin n_err++; $display("FAIL mis_pulse: got %b want 0", bus.misalign_o); end
        e = model(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 5'd0, 32'h12345678));
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 5'd0, 32'h12345678), st, bb);
        n_vec++; if (bus.misalign_o !== 1'b1 || st != 0) begin n_err++; $display("FAIL sw_mis: got mis%b stalls%0d want 1 0", bus.misalign_o, st); end
        e = model(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 5'd3, 32'h0));
        apply(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 5'd3, 32'h0), st, bb);
        n_vec++; if (bus.mw_mdr !== 32'hDEAD80EF) begin n_err++; $display("FAIL sw_mis_nowrite: got %h want dead80ef", bus.mw_mdr); end
    endtask

    task automatic test_special_ops();
        exp_t e; int st; bit bb;
        // memread+memwrite is a store; then an invalid store, a plain ALU op and an aliased address.
        e = model(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h14, 5'd0, 32'h11223344));
        apply(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h14, 5'd0, 32'h11223344), st, bb);
        n_vec++; if (bus.mw_mdr !== 32'hDEAD80EF || st != 2) begin n_err++; $display("FAIL rw_both: got mdr %h stalls %0d want dead80ef 2", bus.mw_mdr, st); end
        e = model(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 5'd9, 32'hCAFEF00D));
        apply(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 5'd9, 32'hCAFEF00D), st, bb);
        n_vec++; if (st != 0 || bus.mw_valid !== 1'b0 || bus.mw_regwrite !== 1'b0) begin
            n_err++; $display("FAIL invalid_op: got stalls %0d v%b w%b want 0 0 0", st, bus.mw_valid, bus.mw_regwrite); end
        e = model(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'hA5A5A5A5, 5'd17, 32'h0));
        apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'hA5A5A5A5, 5'd17, 32'h0), st, bb);
        n_vec++; if (st != 0 || bus.mw_aluout !== 32'hA5A5A5A5 || bus.mw_regwrite !== 1'b1 || bus.mw_rd !== 5'd17) begin
            n_err++; $display("FAIL alu_op: got stalls %0d alu %h w%b rd%0d want 0 a5a5a5a5 1 17", st, bus.mw_aluout, bus.mw_regwrite, bus.mw_rd); end
        e = model(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h14 + NW * 4, 5'd0, 32'h0BADF00D));
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h14 + NW * 4, 5'd0, 32'h0BADF00D), st, bb);
        e = model(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 5'd1, 32'h0));
        apply(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 5'd1, 32'h0), st, bb);
        n_vec++; if (bus.mw_mdr !== 32'h0BADF00D) begin n_err++; $display("FAIL addr_wrap: got %h want 0badf00d", bus.mw_mdr); end
    endtask

    task automatic test_reset_mid();
        exp_t e; int st; bit bb;
        e = model(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 5'd0, 32'h12345678));
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 5'd0, 32'h12345678), st, bb);
        drive(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 5'd0, 32'h00000001));
        #1;
        n_vec++; if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got stall %b want 1", bus.stall_o); end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_vec++; if (bus.stall_o !== 1'b0 || {bus.mw_valid, bus.mw_regwrite, bus.mw_aluout} !== '0) begin
            n_err++; $display("FAIL rstmid_out: got stall %b v%b w%b alu %h want all 0", bus.stall_o, bus.mw_valid, bus.mw_regwrite, bus.mw_aluout); end
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        rst = 1'b0;
        ref_mdr = 32'h0;
        e = model(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 5'd2, 32'h0));
        apply(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 5'd2, 32'h0), st, bb);
        n_vec++; if (bus.mw_mdr !== 32'h12345678) begin n_err++; $display("FAIL rstmid_mem: got %h want 12345678", bus.mw_mdr); end
    endtask

`ifdef MEM_PARITY_EN
    task automatic test_parity();
        exp_t e; int st; bit bb;
        dut.par_q[4][0] = ~dut.par_q[4][0];
        e = model(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 5'd3, 32'h0));
        apply(mk(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 5'd3, 32'h0), st, bb);
        n_vec++; if (bus.parity_err_o !== 1'b1 || bus.mw_mdr !== e.mdr) begin
            n_err++; $display("FAIL parity_hit: got err %b mdr %h want 1 %h", bus.parity_err_o, bus.mw_mdr, e.mdr); end
        @(posedge clk); #1;
        n_vec++; if (bus.parity_err_o !== 1'b0) begin n_err++; $display("FAIL parity_pulse: got %b want 0", bus.parity_err_o); end
    endtask
`endif

    task automatic test_random();
        exp_t e; op_t o; int st; bit bb;
        for (int i = 8; i < 16; i++) begin
            o = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'(i * 4), 5'd0, $urandom);
            e = model(o);
            apply(o, st, bb);
        end
        for (int n = 0; n < 80; n++) begin
            o.valid = ($urandom_range(0, 9) != 0);
            o.memtoreg = 1'($urandom); o.regwrite = 1'($urandom);
            o.ld = 1'($urandom); o.st = 1'($urandom);
            o.size = 2'($urandom); o.uns = 1'($urandom);
            o.addr = (32'($urandom_range(0, 3)) << (DL + 2)) | (32'($urandom_range(8, 15)) << 2) | 32'($urandom_range(0, 3));
            o.rdst = RD_W'($urandom); o.md = $urandom;
            e = model(o);
            apply(o, st, bb);
            n_vec++; if (st != e.stalls || bb) begin n_err++; $display("FAIL rnd%0d_stall: got %0d bubble_bad %b want %0d 0", n, st, bb, e.stalls); end
            n_vec++; if (bus.mw_valid !== e.valid || bus.mw_regwrite !== e.regwrite || bus.mw_memtoreg !== e.memtoreg) begin
                n_err++; $display("FAIL rnd%0d_ctl: got v%b w%b m%b want v%b w%b m%b", n, bus.mw_valid, bus.mw_regwrite,
                                  bus.mw_memtoreg, e.valid, e.regwrite, e.memtoreg); end
            n_vec++; if (bus.mw_aluout !== e.aluout || bus.mw_rd !== e.rd) begin
                n_err++; $display("FAIL rnd%0d_pass: got alu %h rd %0d want %h %0d", n, bus.mw_aluout, bus.mw_rd, e.aluout, e.rd); end
            n_vec++; if (bus.mw_mdr !== e.mdr) begin n_err++; $display("FAIL rnd%0d_mdr: got %h want %h", n, bus.mw_mdr, e.mdr); end
            n_vec++; if (bus.misalign_o !== e.misalign || bus.parity_err_o !== e.perr) begin
                n_err++; $display("FAIL rnd%0d_flags: got mis%b par%b want mis%b par%b", n, bus.misalign_o, bus.parity_err_o, e.misalign, e.perr); end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_word();
        test_byte_half();
        test_misalign();
        test_special_ops();
        test_reset_mid();
`ifdef MEM_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
